extio8x4_axis_rx_arbiter: RTL and testbench
===========================================

Name: extio8x4_axis_rx_arbiter

Overview:
- Shares one 8-bit AXIS transmit path between up to 4 requester byte streams.
- The path is the initiator's rx0 channel, which carries bytes out over the 4-bit extio data plane.
- Round-robin grant, held for a burst that ends on tlast, on MAX_BURST beats, or when the source idles.
- Registered output stage; each beat is tagged with the index of the source that sent it.

Parameters:
- NREQ, 4, number of requesters; legal range 2..4.
- MAX_BURST, 16, maximum beats per grant; legal range 1..256.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tvalid  input  NREQ  per-requester valid.
- s_tready  output  NREQ  per-requester ready; at most one bit set (one-hot or zero).
- s_tdata8  input  8*NREQ  per-requester byte; requester i occupies [8i+7:8i].
- s_tlast  input  NREQ  per-requester end-of-burst marker.
- m_tvalid  output  1  output valid; connects to axis_rx0_tvalid.
- m_tready  input  1  output ready; connects from axis_rx0_tready.
- m_tdata8  output  8  output byte.
- m_tlast  output  1  registered copy of the accepted s_tlast.
- m_tid  output  2  index of the source of the current output beat.
- arb_busy  output  1  high while a grant is held (state GRANT).

Behaviour:
- Reset:
  - Outputs: m_tvalid=0, m_tdata8=0, m_tlast=0, m_tid=0, s_tready=0, arb_busy=0.
  - Internal: state=IDLE, burst count=0, round-robin pointer=NREQ-1, so requester 0 has first priority.
- Reset asserted mid-burst: any held output beat is dropped, with no completion toward m_ready.
- FSM states: IDLE, GRANT.
- IDLE:
  - s_tready=0.
  - If any s_tvalid is set, select the first requester with s_tvalid=1, searching upward (modulo NREQ) from pointer+1.
  - Register the selection as gnt, clear the count, go to GRANT.
  - If no s_tvalid is set, stay in IDLE.
- GRANT:
  - s_tready[gnt] = (!m_tvalid | m_tready); all other s_tready bits are 0.
  - A beat is accepted when s_tvalid[gnt] & s_tready[gnt]:
    - next cycle m_tvalid=1, m_tdata8=s_tdata8[gnt], m_tlast=s_tlast[gnt], m_tid=gnt;
    - count increments.
  - Exit to IDLE with pointer=gnt when any of the following holds:
    - an accepted beat has s_tlast=1;
    - an accepted beat makes count==MAX_BURST;
    - s_tvalid[gnt]=0 in a GRANT cycle (source idle).
- Output register:
  - m_tvalid/m_tdata8/m_tlast/m_tid are held stable while m_tvalid & !m_tready.
  - m_tvalid clears after the handshake unless a new beat is accepted in the same cycle.
  - Full throughput inside a burst: 1 beat/cycle while m_tready=1.
- Latency:
  - s_tvalid rises in IDLE at cycle N; grant and accept at N+1; m_tvalid=1 at N+2.
  - Each grant change costs one IDLE bubble cycle.
- Boundaries:
  - MAX_BURST=1: every beat releases the grant.
  - Counter is 9 bits wide, so it never wraps before the limit.
  - Simultaneous requests are resolved by round-robin only; no requester is serviced twice while another valid requester waits.
  - Requester inputs with index >= NREQ do not exist; m_tid upper bit is 0 when NREQ=2.
- m_tid can change only when a new beat loads the output register.

Optional Feature:
- Macro: EXTIO8X4_ARB_PRIO0_EN.
- When defined, in IDLE:
  - s_tvalid[0]=1 always wins the grant, regardless of pointer.
  - Requester 0's burst ignores MAX_BURST and ends only on tlast or idle.
  - Other requesters arbitrate round-robin as normal.
- When undefined: pure round-robin for all requesters, as described above.

Test Plan:
- After reset, all 4 requesters are valid with data 0xA0..0xA3 (tlast=1, m_tready=1) -> m_tid order 0,1,2,3,0; m_tdata8 0xA0,0xA1,0xA2,0xA3,0xA0; one bubble cycle between grants.
- Requester 2 streams 20 bytes 0x00..0x13 with no tlast, MAX_BURST=16 -> 16 beats 0x00..0x0F with m_tid=2, release, then after a re-grant 0x10..0x13.
- m_tready held 0 for 5 cycles mid-burst -> m_tdata8/m_tid stable, s_tready[gnt]=0 after the first held beat; no byte lost or duplicated when m_tready returns to 1.
- Granted requester 1 drops s_tvalid for 1 cycle while requester 3 is valid -> grant released; next m_tid=3.
- reset asserted for 1 cycle while m_tvalid=1 and state=GRANT -> next cycle m_tvalid=0, arb_busy=0, s_tready=0; next grant goes to requester 0 if it is valid.
- EXTIO8X4_ARB_PRIO0_EN defined, requesters 0 and 1 continuously valid -> requester 0 is granted every arbitration; with it undefined, grants alternate 0,1.

Source files
------------

// File: rtl/extio8x4_axis_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : extio8x4_axis_rx_arbiter
// Purpose  : Shares the initiator's 8-bit AXIS rx0 transmit path (the bytes
//            that leave over the 4-bit extio data plane) between up to NREQ
//            requester byte streams. Round-robin grant, held for a burst that
//            ends on tlast, on MAX_BURST beats, or when the granted source
//            idles. One registered output stage; every output beat carries
//            the index of the requester that produced it on m_tid.
//
// Parameters:
//   NREQ       number of requesters, 2..4
//   MAX_BURST  maximum beats per grant, 1..256
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   s_tvalid   per-requester valid            [NREQ]
//   s_tready   per-requester ready, one-hot or zero [NREQ]
//   s_tdata8   per-requester byte, requester i at [8i+7:8i]
//   s_tlast    per-requester end-of-burst marker [NREQ]
//   m_tvalid   output valid  (to axis_rx0_tvalid)
//   m_tready   output ready  (from axis_rx0_tready)
//   m_tdata8   output byte
//   m_tlast    registered copy of the accepted s_tlast
//   m_tid      index of the source of the current output beat
//   arb_busy   high while a grant is held
//
// Build option:
//   EXTIO8X4_ARB_PRIO0_EN  when defined, a valid requester 0 always wins
//                          arbitration and its bursts are not limited by
//                          MAX_BURST (they end only on tlast or idle).
//
// Revision : 1.0  initial release
// ============================================================================
module extio8x4_axis_rx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      s_tvalid,
  output logic [NREQ-1:0]      s_tready,
  input  logic [8*NREQ-1:0]    s_tdata8,
  input  logic [NREQ-1:0]      s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [7:0]           m_tdata8,
  output logic                 m_tlast,
  output logic [1:0]           m_tid,
  output logic                 arb_busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [8:0] c_MAX_BURST = 9'(MAX_BURST);
  localparam logic [2:0] c_NREQ      = 3'(NREQ);
  // Pointer starts at the last requester so requester 0 is searched first.
  localparam logic [1:0] c_PTR_RST   = 2'(NREQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nx;
  logic [1:0] r_gnt;
  logic [1:0] w_gnt_nx;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nx;
  logic [8:0] r_cnt;
  logic [8:0] w_cnt_nx;

  logic       r_m_tvalid;
  logic [7:0] r_m_tdata8;
  logic       r_m_tlast;
  logic [1:0] r_m_tid;

  // --------------------------------------------------------------------------
  // Requester inputs widened to the 4-requester maximum so the granted lane
  // can be selected with a fixed 2-bit index for every legal NREQ. Lanes at
  // or above NREQ are tied to zero and can never be selected.
  // --------------------------------------------------------------------------
  logic [3:0]  w_tv4;
  logic [3:0]  w_tl4;
  logic [31:0] w_td32;

  assign w_tv4  = 4'(s_tvalid);
  assign w_tl4  = 4'(s_tlast);
  assign w_td32 = 32'(s_tdata8);

  // --------------------------------------------------------------------------
  // Round-robin search: first valid requester strictly after the pointer,
  // wrapping modulo NREQ. The pointer itself is visited last, so the
  // requester that just finished only wins again when nobody else is valid.
  // --------------------------------------------------------------------------
  logic [1:0] w_rr_sel;
  logic       w_rr_found;
  logic [2:0] w_idx;

  always_comb begin
    w_rr_sel   = r_ptr;
    w_rr_found = 1'b0;
    w_idx      = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = 3'(r_ptr) + 3'(k);
      if (w_idx >= c_NREQ) begin
        w_idx = w_idx - c_NREQ;
      end
      if (!w_rr_found && w_tv4[w_idx[1:0]]) begin
        w_rr_sel   = w_idx[1:0];
        w_rr_found = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final selection and burst-limit applicability
  // --------------------------------------------------------------------------
  logic [1:0] w_sel;
  logic       w_burst_capped;

`ifdef EXTIO8X4_ARB_PRIO0_EN
  assign w_sel          = w_tv4[0] ? 2'd0 : w_rr_sel;
  assign w_burst_capped = (r_gnt != 2'd0);
`else
  assign w_sel          = w_rr_sel;
  assign w_burst_capped = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Granted-lane view and handshake
  // --------------------------------------------------------------------------
  logic       w_out_free;   // output register can take a beat this cycle
  logic       w_gnt_valid;
  logic       w_gnt_last;
  logic [7:0] w_gnt_data;
  logic [8:0] w_cnt_inc;
  logic       w_accept;

  assign w_out_free  = !r_m_tvalid || m_tready;
  assign w_gnt_valid = w_tv4[r_gnt];
  assign w_gnt_last  = w_tl4[r_gnt];
  assign w_gnt_data  = w_td32[{r_gnt, 3'b000} +: 8];
  assign w_cnt_inc   = r_cnt + 9'd1;

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rr_found) begin
          w_gnt_nx   = w_sel;
          w_cnt_nx   = 9'd0;
          w_state_nx = ST_GRANT;
        end
      end

      ST_GRANT: begin
        w_accept = w_gnt_valid && w_out_free;
        if (!w_gnt_valid) begin
          // Source went idle: give the path up so others are not starved.
          w_state_nx = ST_IDLE;
          w_ptr_nx   = r_gnt;
        end else if (w_accept) begin
          w_cnt_nx = w_cnt_inc;
          if (w_gnt_last || (w_burst_capped && (w_cnt_inc == c_MAX_BURST))) begin
            w_state_nx = ST_IDLE;
            w_ptr_nx   = r_gnt;
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'd0;
      r_ptr   <= c_PTR_RST;
      r_cnt   <= 9'd0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Output register. A beat is only accepted when the register is free, so
  // the held beat is never overwritten while the sink stalls. Reset drops a
  // held beat outright.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata8 <= 8'd0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= 2'd0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata8 <= w_gnt_data;
      r_m_tlast  <= w_gnt_last;
      r_m_tid    <= r_gnt;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Per-requester ready: only the granted lane, only while the output
  // register can take a beat.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign s_tready[gi] = (r_state == ST_GRANT) && (r_gnt == 2'(gi)) && w_out_free;
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata8 = r_m_tdata8;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;
  assign arb_busy = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_extio8x4_axis_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_extio8x4_axis_rx_arbiter
// Purpose  : Self-checking bench for extio8x4_axis_rx_arbiter. Per-requester
//            source queues drive the inputs; expected beats are queued per
//            requester when stimulus is issued and a monitor pops and
//            compares on every output handshake. Directed scenarios add an
//            expected m_tid order and cycle-spacing checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_extio8x4_axis_rx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;

  logic                clk      = 1'b0;
  logic                reset    = 1'b1;
  logic [NREQ-1:0]     s_tvalid = '0;
  logic [NREQ-1:0]     s_tready;
  logic [8*NREQ-1:0]   s_tdata8 = '0;
  logic [NREQ-1:0]     s_tlast  = '0;
  logic                m_tvalid;
  logic                m_tready = 1'b1;
  logic [7:0]          m_tdata8;
  logic                m_tlast;
  logic [1:0]          m_tid;
  logic                arb_busy;

  always #5 clk = ~clk;

  extio8x4_axis_rx_arbiter #(
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata8 (s_tdata8),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata8 (m_tdata8),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .arb_busy (arb_busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;   // idle cycles before this beat is offered
  } item_t;

  item_t           src_q [NREQ][$];
  item_t           exp_q [NREQ][$];
  int              exp_tid_q[$];
  int              beat_cyc[$];
  item_t           mon_e;

  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              rdy_mode = 0;    // 0: ready, 1: random, 2: stalled
  bit              armed    [NREQ];
  int              gap_left [NREQ];
  logic [NREQ-1:0] hs = '0;
  bit              lat_arm = 1'b0;
  int              first_drive_cyc = 0;
  bit              prev_stall = 1'b0;
  logic [11:0]     prev_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Source driver and sink-ready driver (inputs change 1 time unit after edge)
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        armed[i] = 1'b0;
      end
      if (src_q[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
        armed[i]    = 1'b0;
      end else begin
        if (!armed[i]) begin
          gap_left[i] = src_q[i][0].gap;
          armed[i]    = 1'b1;
        end
        if (gap_left[i] > 0) begin
          gap_left[i]--;
          s_tvalid[i] = 1'b0;
        end else begin
          s_tvalid[i]       = 1'b1;
          s_tdata8[8*i +: 8] = src_q[i][0].d;
          s_tlast[i]        = src_q[i][0].l;
        end
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(0, 9) < 7);
      default: m_tready = 1'b0;
    endcase
    if (lat_arm && (|s_tvalid)) begin
      first_drive_cyc = cyc;
      lat_arm         = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard (samples on the falling edge)
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    hs = s_tvalid & s_tready;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_stable", 32'({m_tvalid, m_tlast, m_tid, m_tdata8}), 32'(prev_out));
      end
      chk("tready_onehot0", 32'($onehot0(s_tready)), 32'd1);
      if (m_tvalid && !m_tready) begin
        chk("tready_in_stall", 32'(s_tready), 32'd0);
      end
      if (m_tvalid && m_tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q[m_tid].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got tid %0d data 0x%0h, expected no beat", m_tid, m_tdata8);
        end else begin
          mon_e = exp_q[m_tid].pop_front();
          chk("beat_data", 32'(m_tdata8), 32'(mon_e.d));
          chk("beat_last", 32'(m_tlast), 32'(mon_e.l));
        end
        if (exp_tid_q.size() > 0) begin
          chk("tid_order", 32'(m_tid), 32'(exp_tid_q.pop_front()));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tvalid, m_tlast, m_tid, m_tdata8};
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic add(input int s, input logic [7:0] d, input logic l, input int gap);
    item_t it;
    it.d   = d;
    it.l   = l;
    it.gap = gap;
    src_q[s].push_back(it);
    exp_q[s].push_back(it);
  endtask

  function automatic bit all_empty();
    bit e = (exp_tid_q.size() == 0);
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // One-cycle reset; flushes all pending stimulus. Returns on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    exp_tid_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    beat_cyc.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (n < 3000 && !(all_empty() && !m_tvalid)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles without draining, expected drain within 3000", name, n);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    // Reset values
    do_reset();
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata8", 32'(m_tdata8), 32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_m_tid",    32'(m_tid),    32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);

    // All four requesters with single-beat bursts
    rdy_mode = 0;
    lat_arm  = 1'b1;
    add(0, 8'hA0, 1'b1, 0);
    add(1, 8'hA1, 1'b1, 0);
    add(2, 8'hA2, 1'b1, 0);
    add(3, 8'hA3, 1'b1, 0);
    add(0, 8'hA0, 1'b1, 0);
`ifdef EXTIO8X4_ARB_PRIO0_EN
    exp_tid_q = '{0, 0, 1, 2, 3};
`else
    exp_tid_q = '{0, 1, 2, 3, 0};
`endif
    wait_drain("rr4");
    chk("rr4_beats", 32'(beat_cyc.size()), 32'd5);
    if (beat_cyc.size() == 5) begin
      chk("rr4_latency", 32'(beat_cyc[0]), 32'(first_drive_cyc + 2));
      for (int k = 1; k < 5; k++) begin
        chk("rr4_spacing", 32'(beat_cyc[k] - beat_cyc[k-1]), 32'd2);
      end
    end

    // MAX_BURST split of a 20-byte stream without tlast
    do_reset();
    for (int b = 0; b < 20; b++) begin
      add(2, 8'(b), 1'b0, 0);
      exp_tid_q.push_back(2);
    end
    wait_drain("maxburst");
    chk("maxburst_beats", 32'(beat_cyc.size()), 32'd20);
    if (beat_cyc.size() == 20) begin
      chk("maxburst_in_burst", 32'(beat_cyc[MAX_BURST-1] - beat_cyc[MAX_BURST-2]), 32'd1);
      chk("maxburst_bubble",   32'(beat_cyc[MAX_BURST]   - beat_cyc[MAX_BURST-1]), 32'd2);
      chk("maxburst_second",   32'(beat_cyc[19] - beat_cyc[MAX_BURST]), 32'd3);
    end

    // Sink stall for five cycles mid-burst
    do_reset();
    for (int b = 0; b < 8; b++) begin
      add(0, 8'h50 + 8'(b), (b == 7), 0);
    end
    begin
      int n = 0;
      while (n < 200 && beat_cyc.size() < 3) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reach", 32'(beat_cyc.size() >= 3), 32'd1);
    end
    rdy_mode = 2;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid",  32'(m_tvalid), 32'd1);
      chk("stall_tready", 32'(s_tready), 32'd0);
    end
    rdy_mode = 0;
    wait_drain("stall");
    chk("stall_beats", 32'(beat_cyc.size()), 32'd8);

    // Granted source drops valid for one cycle while requester 3 waits
    do_reset();
    add(1, 8'h10, 1'b0, 0);
    add(1, 8'h11, 1'b0, 1);
    add(1, 8'h12, 1'b1, 0);
    add(3, 8'h30, 1'b1, 0);
    exp_tid_q = '{1, 3, 1, 1};
    wait_drain("idle_release");

    // Reset while a beat is held and the grant is active
    do_reset();
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) begin
      add(1, 8'h70 + 8'(b), 1'b0, 0);
    end
    begin
      int n = 0;
      while (n < 50 && !m_tvalid) begin
        @(negedge clk);
        n++;
      end
    end
    chk("midrst_pre_valid", 32'(m_tvalid), 32'd1);
    chk("midrst_pre_busy",  32'(arb_busy), 32'd1);
    do_reset();
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_arb_busy", 32'(arb_busy), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    rdy_mode = 0;
    add(0, 8'h80, 1'b1, 0);
    add(1, 8'h81, 1'b1, 0);
    exp_tid_q = '{0, 1};
    wait_drain("midrst");

    // Requesters 0 and 1 continuously valid
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add(0, 8'hC0 + 8'(k), 1'b1, 0);
      add(1, 8'hD0 + 8'(k), 1'b1, 0);
    end
`ifdef EXTIO8X4_ARB_PRIO0_EN
    exp_tid_q = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_tid_q = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    wait_drain("two_req");

    // Randomized traffic with random backpressure
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < NREQ; i++) begin
      for (int b = 0; b < 30; b++) begin
        add(i, 8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      end
    end
    wait_drain("random");
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
